// File: rtl/cnn_ecg_stream_if.sv
// Bus bundle for cnn_ecg_stream.
//   master : producer/controller side (FIR stage, CPU config, alert logic)
//   slave  : the classifier itself
// Signals:
//   in_valid/in_ready/in_data            sample stream (one sample per handshake)
//   coef_we/coef_addr/coef_wdata         weight write, addr = f*KERNEL_LEN + t
//   thr_we/thr_sel/thr_wdata             per-filter threshold write
//   busy                                 high while the convolution runs
//   res_valid/res_ready                  result handshake
//   class_out/feat_out                   class flags and pooled features
interface cnn_ecg_stream_if #(
  parameter int DATA_W     = 16,
  parameter int KERNEL_LEN = 3,
  parameter int NUM_FILT   = 8,
  parameter int ACC_W      = 36
);
  localparam int CA_W = (NUM_FILT * KERNEL_LEN > 1) ? $clog2(NUM_FILT * KERNEL_LEN) : 1;
  localparam int TS_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;

  logic                            in_valid;
  logic                            in_ready;
  logic signed [DATA_W-1:0]        in_data;
  logic                            coef_we;
  logic [CA_W-1:0]                 coef_addr;
  logic signed [DATA_W-1:0]        coef_wdata;
  logic                            thr_we;
  logic [TS_W-1:0]                 thr_sel;
  logic signed [ACC_W-1:0]         thr_wdata;
  logic                            busy;
  logic                            res_valid;
  logic                            res_ready;
  logic [NUM_FILT-1:0]             class_out;
  logic [NUM_FILT*ACC_W-1:0]       feat_out;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata,
           thr_we, thr_sel, thr_wdata, res_ready,
    input  in_ready, busy, res_valid, class_out, feat_out
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata,
           thr_we, thr_sel, thr_wdata, res_ready,
    output in_ready, busy, res_valid, class_out, feat_out
  );
endinterface

// File: rtl/cnn_ecg_stream.sv
// Streaming ECG CNN classifier.
// Buffers SEG_LEN samples (FILL), then runs a time-multiplexed valid 1D
// convolution with one signed MAC per cycle over NUM_FILT filters (COMPUTE).
// Each filter's output goes through ReLU + global max-pool and is compared
// against a programmable threshold; flags and features are presented on a
// valid/ready result port (DONE).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears weights and thresholds too)
//   bus    cnn_ecg_stream_if.slave (sample stream, config writes, result)
module cnn_ecg_stream #(
  parameter int DATA_W     = 16,
  parameter int SEG_LEN    = 32,
  parameter int KERNEL_LEN = 3,
  parameter int NUM_FILT   = 8,
  parameter int ACC_W      = 36
) (
  input  logic            clk,
  input  logic            rst_n,
  cnn_ecg_stream_if.slave bus
);
  localparam int NUM_COEF = NUM_FILT * KERNEL_LEN;
  localparam int NUM_POS  = SEG_LEN - KERNEL_LEN + 1;
  localparam int CA_W     = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
  localparam int TS_W     = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam int IW       = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
  localparam int KW       = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam int FW       = TS_W;
  localparam logic [CA_W:0] NUM_COEF_C = (CA_W+1)'(NUM_COEF);
  localparam logic [TS_W:0] NUM_FILT_C = (TS_W+1)'(NUM_FILT);

  typedef enum logic [1:0] {FILL, COMPUTE, DONE} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] seg_buf [SEG_LEN];
  logic signed [DATA_W-1:0] coef    [NUM_COEF];
  logic signed [ACC_W-1:0]  thr     [NUM_FILT];
  logic signed [ACC_W-1:0]  maxreg  [NUM_FILT];
  logic signed [ACC_W-1:0]  acc;

  logic [IW-1:0] wr_idx, p_cnt;
  logic [KW-1:0] t_cnt;
  logic [FW-1:0] f_cnt;

  logic                  res_valid_q;
  logic [NUM_FILT-1:0]   class_q;
  logic [NUM_FILT*ACC_W-1:0] feat_q;

  logic in_ready, busy, accept, last_wr;
  logic last_t, last_p, last_f, last_mac;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && last_wr)              state_nxt = COMPUTE;
      COMPUTE: if (last_mac)                       state_nxt = DONE;
      DONE:    if (res_valid_q && bus.res_ready)   state_nxt = FILL;
      default:                                     state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      FILL:    in_ready = 1'b1;
      COMPUTE: busy     = 1'b1;
      default: ;
    endcase
  end

  assign accept   = bus.in_valid && in_ready;
  assign last_wr  = (wr_idx == IW'(SEG_LEN-1));
  assign last_t   = (t_cnt == KW'(KERNEL_LEN-1));
  assign last_p   = (p_cnt == IW'(NUM_POS-1));
  assign last_f   = (f_cnt == FW'(NUM_FILT-1));
  assign last_mac = busy && last_t && last_p && last_f;

  // ---------------- MAC datapath ----------------
  logic [IW-1:0]              rd_idx;
  logic [CA_W-1:0]            coef_idx;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    sum, pool_max;

  assign rd_idx   = p_cnt + IW'(t_cnt);
  assign coef_idx = CA_W'(f_cnt) * CA_W'(KERNEL_LEN) + CA_W'(t_cnt);
  assign prod     = seg_buf[rd_idx] * coef[coef_idx];
  // Tap 0 starts a fresh dot product instead of clearing acc a cycle early.
  assign sum      = ((t_cnt == '0) ? '0 : acc) + ACC_W'(prod);
  // maxreg starts at 0, so negative sums never win: ReLU folded into pooling.
  assign pool_max = (sum > maxreg[f_cnt]) ? sum : maxreg[f_cnt];

  // Final features as they will look after the last MAC, so results can be
  // registered on the same edge that enters DONE.
  logic signed [ACC_W-1:0]   feat_fin [NUM_FILT];
  logic [NUM_FILT-1:0]       class_fin;
  logic [NUM_FILT*ACC_W-1:0] feat_flat;

  for (genvar g = 0; g < NUM_FILT; g++) begin : g_filt
    assign feat_fin[g]  = (f_cnt == FW'(g)) ? pool_max : maxreg[g];
    assign class_fin[g] = (feat_fin[g] >= thr[g]);
    assign feat_flat[g*ACC_W +: ACC_W] = feat_fin[g];
  end

  always_ff @(posedge clk)
    if (accept) seg_buf[wr_idx] <= bus.in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx      <= '0;
      p_cnt       <= '0;
      t_cnt       <= '0;
      f_cnt       <= '0;
      acc         <= '0;
      res_valid_q <= 1'b0;
      class_q     <= '0;
      feat_q      <= '0;
      for (int i = 0; i < NUM_FILT; i++) maxreg[i] <= '0;
    end else begin
      case (state)
        FILL: if (accept) begin
          wr_idx <= last_wr ? '0 : wr_idx + IW'(1);
          if (last_wr)
            for (int i = 0; i < NUM_FILT; i++) maxreg[i] <= '0;
        end
        COMPUTE: begin
          acc <= sum;
          if (last_t) begin
            maxreg[f_cnt] <= pool_max;
            t_cnt <= '0;
            if (last_p) begin
              p_cnt <= '0;
              f_cnt <= last_f ? '0 : f_cnt + FW'(1);
            end else begin
              p_cnt <= p_cnt + IW'(1);
            end
          end else begin
            t_cnt <= t_cnt + KW'(1);
          end
          if (last_mac) begin
            res_valid_q <= 1'b1;
            class_q     <= class_fin;
            feat_q      <= feat_flat;
          end
        end
        DONE: if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // ---------------- configuration ----------------
  // Writes are blocked while busy so a segment always sees one weight set.
  logic cfg_en;
  assign cfg_en = !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEF; i++) coef[i] <= '0;
      for (int i = 0; i < NUM_FILT; i++) thr[i]  <= '0;
    end else begin
      if (cfg_en && bus.coef_we && ({1'b0, bus.coef_addr} < NUM_COEF_C))
        coef[bus.coef_addr] <= bus.coef_wdata;
      if (cfg_en && bus.thr_we && ({1'b0, bus.thr_sel} < NUM_FILT_C))
        thr[bus.thr_sel] <= bus.thr_wdata;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.res_valid = res_valid_q;
  assign bus.class_out = class_q;
  assign bus.feat_out  = feat_q;
endmodule
